// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes,
// FSM state encoding, the divide-by-zero result word and the op decoder.
package muldiv_seq_pkg;

  localparam logic [4:0] SIG_ALU_ADD   = 5'd0;
  localparam logic [4:0] SIG_ALU_SUB   = 5'd1;
  localparam logic [4:0] SIG_ALU_AND   = 5'd2;
  localparam logic [4:0] SIG_ALU_OR    = 5'd3;
  localparam logic [4:0] SIG_ALU_MULT  = 5'd12;
  localparam logic [4:0] SIG_ALU_MULTU = 5'd13;
  localparam logic [4:0] SIG_ALU_DIV   = 5'd14;
  localparam logic [4:0] SIG_ALU_DIVU  = 5'd15;

  // Low word committed for a divide by zero; the high word is the dividend.
  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == SIG_ALU_MULT) || (op == SIG_ALU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == SIG_ALU_DIV) || (op == SIG_ALU_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == SIG_ALU_MULT) || (op == SIG_ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle of the EX-side request, the multiplier/divider unit handshakes and
// the HI/LO write port. The sequencer uses the slave view; the pipeline and
// units around it use the master view.
interface muldiv_seq_if;
  logic        req_valid;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_next;
  logic        stall_o;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic        div_done;
  logic [63:0] div_result;
  logic        hilo_we;
  logic [63:0] hilo_o;
  logic        div_by_zero;
  logic        timeout_err;

  modport slave (
    input  req_valid, op, a, b, flush, stall_next,
    input  mul_done, mul_result, div_done, div_result,
    output stall_o, mul_start, mul_signed, mul_a, mul_b,
    output div_start, div_signed, div_a, div_b, div_annul,
    output hilo_we, hilo_o, div_by_zero, timeout_err
  );

  modport master (
    output req_valid, op, a, b, flush, stall_next,
    output mul_done, mul_result, div_done, div_result,
    input  stall_o, mul_start, mul_signed, mul_a, mul_b,
    input  div_start, div_signed, div_a, div_b, div_annul,
    input  hilo_we, hilo_o, div_by_zero, timeout_err
  );
endinterface

// File: rtl/muldiv_seq_watchdog.sv
// Occupancy watchdog: counts cycles spent waiting on a unit and flags the
// cycle in which the wait budget is used up.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Restart on entry to a unit state, then count every cycle spent there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer between EX and the multi-cycle multiplier/divider. Launches one
// request, stalls the pipeline while the unit works, and commits the 64-bit
// result to HI/LO with a single write pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic          clk,
  input logic          rst,
  muldiv_seq_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic        launch;
  logic        launch_mul;
  logic        launch_div;
  logic        b_zero;
  logic        in_unit;
  logic        expire;
  logic        stall_c;
  logic        mul_start_c;
  logic        div_start_c;
  logic        div_annul_c;
  logic        hilo_we_c;
  logic        div_by_zero_c;
  logic        timeout_err_c;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] div_a_q;
  logic [31:0] div_b_q;
  logic        mul_signed_q;
  logic        div_signed_q;
  logic [63:0] result_q;

  // Launch decode; gated by reset so nothing can pulse while rst is low.
  always_comb begin
    launch     = rst && (state == ST_IDLE) && bus.req_valid &&
                 is_muldiv(bus.op) && !bus.flush;
    launch_mul = launch && is_mul_op(bus.op);
    launch_div = launch && is_div_op(bus.op);
    b_zero     = (bus.b == 32'd0);
    in_unit    = (state == ST_MUL) || (state == ST_DIV);
  end

  muldiv_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch),
    .enable (in_unit),
    .expire (expire)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control outputs; flush beats done, done beats the watchdog.
  always_comb begin
    state_next    = state;
    stall_c       = 1'b0;
    mul_start_c   = 1'b0;
    div_start_c   = 1'b0;
    div_annul_c   = 1'b0;
    hilo_we_c     = 1'b0;
    div_by_zero_c = 1'b0;
    timeout_err_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          stall_c = 1'b1;
          if (launch_mul) begin
            state_next = ST_MUL;
          end else if (b_zero) begin
            div_by_zero_c = 1'b1;
            state_next    = ST_HOLD;
          end else begin
            state_next = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        stall_c     = 1'b1;
        mul_start_c = 1'b1;
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (bus.mul_done) begin
          state_next = ST_HOLD;
        end else if (expire) begin
          timeout_err_c = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      ST_DIV: begin
        stall_c     = 1'b1;
        div_start_c = 1'b1;
        if (bus.flush) begin
          div_annul_c = 1'b1;
          state_next  = ST_IDLE;
        end else if (bus.div_done) begin
          state_next = ST_HOLD;
        end else if (expire) begin
          div_annul_c   = 1'b1;
          timeout_err_c = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (!bus.stall_next) begin
          hilo_we_c  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latches and result capture; operands stay put until the next launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signed_q <= 1'b0;
      result_q     <= '0;
    end else if (launch_mul) begin
      mul_a_q      <= bus.a;
      mul_b_q      <= bus.b;
      mul_signed_q <= is_signed_op(bus.op);
    end else if (launch_div) begin
      div_a_q      <= bus.a;
      div_b_q      <= bus.b;
      div_signed_q <= is_signed_op(bus.op);
      if (b_zero) begin
        result_q <= {bus.a, DIV_BY_ZERO_LO};
      end
    end else if ((state == ST_MUL) && bus.mul_done && !bus.flush) begin
      result_q <= bus.mul_result;
    end else if ((state == ST_DIV) && bus.div_done && !bus.flush) begin
      result_q <= bus.div_result;
    end
  end

  assign bus.stall_o     = stall_c;
  assign bus.mul_start   = mul_start_c;
  assign bus.mul_signed  = mul_signed_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.div_start   = div_start_c;
  assign bus.div_signed  = div_signed_q;
  assign bus.div_a       = div_a_q;
  assign bus.div_b       = div_b_q;
  assign bus.div_annul   = div_annul_c;
  assign bus.hilo_we     = hilo_we_c;
  assign bus.hilo_o      = result_q;
  assign bus.div_by_zero = div_by_zero_c;
  assign bus.timeout_err = timeout_err_c;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer between the EX stage and the multi-cycle multiplier and divider units.
- Accepts one MULT/MULTU/DIV/DIVU request, launches the matching unit, and stalls the pipeline until the result is captured.
- Commits the 64-bit result to the HI/LO register with a single write pulse.
- Handles pipeline flush mid-operation, divide-by-zero fast path, and a hung-unit watchdog.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in MUL/DIV before forced abort; must be greater than the slowest unit latency.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX holds a valid instruction.
- op  in  5  ALU op code (shared SIG_ALU_* encoding); only MULT/MULTU/DIV/DIVU act.
- a  in  32  rs operand.
- b  in  32  rt operand.
- flush  in  1  exception/flush kills the EX instruction.
- stall_next  in  1  downstream stage not advancing.
- stall_o  out  1  hold EX and earlier stages.
- mul_start  out  1  level: multiplier operate enable.
- mul_signed  out  1  signed multiply.
- mul_a, mul_b  out  32 each  latched operands.
- mul_done  in  1  multiplier result valid.
- mul_result  in  64  {HI,LO}.
- div_start  out  1  level: divider operate enable.
- div_signed  out  1  signed divide.
- div_a, div_b  out  32 each  latched operands.
- div_annul  out  1  one-cycle cancel pulse to the divider.
- div_done  in  1  divider result valid.
- div_result  in  64  {remainder,quotient}.
- hilo_we  out  1  one-cycle HI/LO write enable.
- hilo_o  out  64  value to write.
- div_by_zero  out  1  one-cycle pulse on a DIV/DIVU with b==0.
- timeout_err  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset (rst=0, async): state=IDLE. Every output is 0, including mul_a/mul_b/div_a/div_b and hilo_o. Watchdog counter=0.
- States and transitions:
  - IDLE: when req_valid & is_muldiv(op) & !flush:
    - latch a, b and sign (sign=1 for MULT/DIV);
    - MULT/MULTU -> MUL;
    - DIV/DIVU with b!=0 -> DIV;
    - DIV/DIVU with b==0 -> HOLD with result {a, 32'hFFFF_FFFF} and a div_by_zero pulse in the same cycle.
  - MUL: mul_start=1. On mul_done, capture mul_result -> HOLD.
  - DIV: div_start=1. On div_done, capture div_result -> HOLD.
  - HOLD: stall_o=0 and start signals=0.
    - If !stall_next: hilo_we=1, hilo_o=captured result -> IDLE.
    - Else remain in HOLD; the request is not relaunched.
- stall_o = (IDLE & launch condition) | MUL | DIV. It is combinational, so the stall begins in the launch cycle.
- Latency: the result is committed 1 cycle after unit done when stall_next=0. The b==0 fast path commits 1 cycle after launch.
- Operand ports hold their latched values for the entire MUL/DIV occupancy. They are independent of the a/b inputs after launch.
- Flush:
  - In MUL/DIV/HOLD -> IDLE next cycle, start deasserted, no hilo_we.
  - In DIV, div_annul=1 for that cycle.
  - Flush in IDLE suppresses launch.
  - Flush in the same cycle as done: flush wins and the result is discarded.
- Watchdog:
  - The counter clears on entry to MUL/DIV and increments each cycle in those states.
  - When count==TIMEOUT_CYCLES-1 without done -> IDLE, timeout_err pulse, div_annul pulse if in DIV, stall released, no hilo_we.
- Done asserted in IDLE/HOLD, or done from the non-active unit, is ignored.
- Non-mul/div ops never touch state. MFHI/MFLO forwarding is outside this block.
- hilo_we and div_by_zero/timeout_err are never asserted while rst=0.

Decomposition:
- Shared package/header (alongside the SIG_ALU_* defines) holds:
  - the state encoding (IDLE=2'd0, MUL=2'd1, DIV=2'd2, HOLD=2'd3);
  - the div-by-zero result constant;
  - an is_muldiv op-decode macro.
- Natural sub-module: muldiv_watchdog (counter plus compare, clear/enable inputs, expire pulse output). Everything else stays flat.

Test Plan:
- MULT a=-3, b=5, unit done after 4 cycles:
  - stall_o high 5 cycles (launch cycle plus 4 MUL cycles);
  - mul_signed=1;
  - next cycle hilo_we=1, hilo_o=64'hFFFF_FFFF_FFFF_FFF1.
- DIVU a=100, b=7, div_done after 33 cycles with result {2,14}:
  - hilo_o=64'h0000_0002_0000_000E;
  - exactly one hilo_we pulse;
  - div_start dropped in HOLD.
- DIV b=0, a=9:
  - no div_start;
  - div_by_zero pulse in the launch cycle;
  - next cycle hilo_o=64'h0000_0009_FFFF_FFFF with hilo_we=1.
- DIV in flight with flush asserted at cycle 10:
  - div_annul pulse;
  - IDLE the next cycle;
  - stall_o=0;
  - no hilo_we even if div_done arrives in the same cycle.
- MULTU with mul_done never asserted, TIMEOUT_CYCLES=64:
  - timeout_err pulses after 64 MUL cycles;
  - stall released;
  - no hilo_we.
- HOLD with stall_next=1 for 3 cycles, then 0:
  - no relaunch;
  - single hilo_we on the 4th cycle.
- rst pulled low mid-DIV:
  - all outputs 0 asynchronously;
  - IDLE after release.
